// File: rtl/fitness_pkg.sv
// Shared types and helpers for the fitness evaluator: FSM state encoding and
// the fitness width function.
package fitness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FIN    = 2'd3
    } fe_state_t;

    // Width needed to hold a score from 0 up to n_out * 2**n_in inclusive.
    function automatic int fit_w(input int n_in, input int n_out);
        return $clog2(n_out * (2 ** n_in) + 1);
    endfunction

endpackage

// File: rtl/fitness_eval_popcount_out.sv
// Combinational population count over the OUT circuit output bits,
// producing a result as wide as the fitness accumulator.
module popcount_out #(
    parameter int OUT   = 1,
    parameter int FIT_W = 3
) (
    input  logic [OUT-1:0]   bits,
    output logic [FIT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int k = 0; k < OUT; k++) begin
            count = count + FIT_W'(bits[k]);
        end
    end

endmodule

// File: rtl/fitness_eval.sv
// Sequential fitness evaluator: walks every input vector through the evolved
// circuit, waits for it to settle, and scores stable bits against a target table.
module fitness_eval
    import fitness_pkg::*;
#(
    parameter int IN      = 2,
    parameter int OUT     = 1,
    parameter int SETTLE  = 2,
    localparam int FIT_W  = fit_w(IN, OUT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [OUT-1:0][2**IN-1:0] target,
    input  logic [OUT-1:0]            circ_out,
    output logic [IN-1:0]             inp,
    output logic                      busy,
    output logic                      done,
    output logic [FIT_W-1:0]          fitness,
    output logic                      perfect
);

    localparam int NVEC   = 2 ** IN;
    localparam int MAX    = OUT * NVEC;
    localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    fe_state_t                 state_q, state_d;
    logic [OUT-1:0][NVEC-1:0]  tgt_q, tgt_d;
    logic [OUT-1:0]            prev_q, prev_d;
    logic [IN-1:0]             vec_q, vec_d;
    logic [SCNT_W-1:0]         scnt_q, scnt_d;
    logic [FIT_W-1:0]          acc_q, acc_d;
    logic [FIT_W-1:0]          fitness_q, fitness_d;
    logic                      perfect_q, perfect_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [OUT-1:0]            match;
    logic [FIT_W-1:0]          match_cnt;
    logic [FIT_W-1:0]          acc_sum;
    logic                      settle_end;
    logic                      last_vec;

    assign settle_end = (scnt_q == SCNT_W'(SETTLE - 1));
    assign last_vec   = (vec_q == {IN{1'b1}});

    // A bit scores only if it held its value from the last settle cycle
    // into CHECK and agrees with the latched target for this vector.
    always_comb begin
        match = '0;
        for (int k = 0; k < OUT; k++) begin
            match[k] = ~(circ_out[k] ^ prev_q[k]) & ~(circ_out[k] ^ tgt_q[k][vec_q]);
        end
    end

    popcount_out #(
        .OUT   (OUT),
        .FIT_W (FIT_W)
    ) u_popcount (
        .bits  (match),
        .count (match_cnt)
    );

    assign acc_sum = acc_q + match_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start)      state_d = ST_SETTLE;
            ST_SETTLE: if (settle_end) state_d = ST_CHECK;
            ST_CHECK:  state_d = last_vec ? ST_FIN : ST_SETTLE;
            ST_FIN:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Results are registered on the final CHECK so that done, fitness and
    // perfect all become visible together during the FIN cycle.
    always_comb begin
        tgt_d     = tgt_q;
        prev_d    = prev_q;
        vec_d     = vec_q;
        scnt_d    = scnt_q;
        acc_d     = acc_q;
        fitness_d = fitness_q;
        perfect_d = perfect_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tgt_d  = target;
                    vec_d  = '0;
                    acc_d  = '0;
                    scnt_d = '0;
                    busy_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                scnt_d = scnt_q + 1'b1;
                if (settle_end) begin
                    prev_d = circ_out;
                end
            end
            ST_CHECK: begin
                acc_d = acc_sum;
                if (last_vec) begin
                    fitness_d = acc_sum;
                    perfect_d = (acc_sum == FIT_W'(MAX));
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    vec_d     = '0;
                end else begin
                    vec_d  = vec_q + 1'b1;
                    scnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q     <= '0;
            prev_q    <= '0;
            vec_q     <= '0;
            scnt_q    <= '0;
            acc_q     <= '0;
            fitness_q <= '0;
            perfect_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tgt_q     <= tgt_d;
            prev_q    <= prev_d;
            vec_q     <= vec_d;
            scnt_q    <= scnt_d;
            acc_q     <= acc_d;
            fitness_q <= fitness_d;
            perfect_q <= perfect_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // The vector register drives the circuit directly, so inp never glitches.
    assign inp     = vec_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign fitness = fitness_q;
    assign perfect = perfect_q;

endmodule
